// File: rtl/prewish_button_poller_pkg.sv
// Shared types for the prewish status poller: state encoding, status byte, edge terms.
package prewish_button_poller_pkg;

    localparam int STATUS_W = 8;

    typedef logic [STATUS_W-1:0] status_t;

    // Encoding shared with the responder side of the handshake.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b11,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        status_t pressed;
        status_t released;
    } edges_t;

    function automatic edges_t status_edges(input status_t cap, input status_t prev);
        edges_t e;
        e.pressed  = cap & ~prev;
        e.released = ~cap & prev;
        return e;
    endfunction

endpackage

// File: rtl/prewish_button_poller.sv
// Initiator side of the prewish strobe/data status handshake: periodic poll, reply capture, press/release edges.
// Nominal poll start to o_valid is 4 cycles; an unanswered poll is abandoned after TIMEOUT clocks in WAIT.
module prewish_button_poller
    import prewish_button_poller_pkg::*;
#(
    parameter int              POLL_PERIOD  = 100000,
    parameter int              POLL_BITS    = 17,
    parameter int              TIMEOUT      = 15,
    parameter int              TIMEOUT_BITS = 4,
    parameter logic [7:0]      REQ_MASK     = 8'hFF
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    input  logic       i_poll_now,
    output logic [7:0] o_status,
    output logic [7:0] o_pressed,
    output logic [7:0] o_released,
    output logic       o_valid,
    output logic       o_timeout
);

    localparam logic [POLL_BITS-1:0]    POLL_LAST = POLL_BITS'(POLL_PERIOD - 1);
    localparam logic [TIMEOUT_BITS-1:0] WAIT_LAST = TIMEOUT_BITS'(TIMEOUT - 1);

    state_t                  state_q;
    state_t                  state_nxt;
    logic [POLL_BITS-1:0]    poll_cnt_q;
    logic [POLL_BITS-1:0]    poll_cnt_nxt;
    logic [TIMEOUT_BITS-1:0] wait_cnt_q;
    logic [TIMEOUT_BITS-1:0] wait_cnt_nxt;
    logic                    reply;
    logic                    expire;
    status_t                 cap_nxt;
    edges_t                  edges;

    assign DAT_O   = REQ_MASK;
    assign cap_nxt = DAT_I & REQ_MASK;
    assign edges   = status_edges(cap_nxt, o_status);

    always_comb begin
        state_nxt = state_q;
        reply     = 1'b0;
        expire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (poll_cnt_q == POLL_LAST || i_poll_now) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A reply on the last permitted cycle wins over the timeout.
                if (STB_I) begin
                    reply     = 1'b1;
                    state_nxt = ST_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        poll_cnt_nxt = '0;
        wait_cnt_nxt = '0;
        if (state_q == ST_IDLE && state_nxt == ST_IDLE) begin
            poll_cnt_nxt = poll_cnt_q + POLL_BITS'(1);
        end
        if (state_q == ST_WAIT && state_nxt == ST_WAIT) begin
            wait_cnt_nxt = wait_cnt_q + TIMEOUT_BITS'(1);
        end
    end

    // The capture register is o_status itself: edges are formed from the
    // incoming byte at the capture edge so they land together with o_valid.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            poll_cnt_q <= '0;
            wait_cnt_q <= '0;
            STB_O      <= 1'b0;
            o_valid    <= 1'b0;
            o_timeout  <= 1'b0;
            o_status   <= '0;
            o_pressed  <= '0;
            o_released <= '0;
        end else begin
            state_q    <= state_nxt;
            poll_cnt_q <= poll_cnt_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            STB_O      <= (state_nxt == ST_REQ);
            o_valid    <= reply;
            o_timeout  <= expire;
            if (reply) begin
                o_status   <= cap_nxt;
                o_pressed  <= edges.pressed;
                o_released <= edges.released;
            end
        end
    end

endmodule
